// File: rtl/sram_pkg.sv
// Shared SRAM periphery constants: typical supply/threshold levels and the
// wordline sequencer FSM encoding.
package sram_pkg;

   localparam real VDD_TYP = 1.5;
   localparam real VSS_TYP = 0.0;
   localparam real VTH_TYP = 0.8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRECHARGE,
      ST_WL_ON,
      ST_RECOVER
   } wl_state_e;

   // Phase counter width: must hold 0 .. max(a,b)-1.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary row address to one-hot row select; oor flags addresses >= ROWS,
// which leave every select bit low.
module onehot_decoder #(
   parameter  int ROWS = 16,
   localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic [AW-1:0]   addr,
   output logic [ROWS-1:0] onehot,
   output logic            oor
);

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign onehot[r] = (addr == AW'(r));
   end

   assign oor = ~|onehot;

endmodule

// File: rtl/wordline_sequencer.sv
// SRAM access sequencer: precharge bitlines, pulse one decoded wordline,
// recover, then signal done. Real-valued levels exist only at the ports.
module wordline_sequencer
   import sram_pkg::*;
#(
   parameter  int  ROWS      = 16,
   parameter  int  PRE_CYC   = 2,
   parameter  int  PULSE_CYC = 3,
   parameter  real VDD       = VDD_TYP,
   parameter  real VSS       = VSS_TYP,
   parameter  real VTH       = VTH_TYP,
   localparam int  AW        = $clog2(ROWS)
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  real  addr   [0:AW-1],
   output real  wl_out [0:ROWS-1],
   output real  pre_out,
   output logic busy,
   output logic done,
   output logic err
);

   localparam int            CW         = cnt_width(PRE_CYC, PULSE_CYC);
   localparam logic [CW-1:0] PRE_LAST   = CW'(PRE_CYC - 1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);

   wl_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [ROWS-1:0] row_sel_q, row_sel_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [AW-1:0]   addr_thr;
   logic [ROWS-1:0] dec_onehot;
   logic            dec_oor;

   for (genvar i = 0; i < AW; i++) begin : g_thr
      assign addr_thr[i] = (addr[i] >= VTH);
   end

   onehot_decoder #(.ROWS(ROWS)) u_dec (
      .addr   (addr_thr),
      .onehot (dec_onehot),
      .oor    (dec_oor)
   );

   // The captured address is held already decoded, so wl_out depends only on flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         row_sel_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         row_sel_q <= row_sel_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_sel_d = row_sel_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               row_sel_d = dec_onehot;
               cnt_d     = '0;
               if (dec_oor) err_d   = 1'b1;
               else         state_d = ST_PRECHARGE;
            end
         end
         ST_PRECHARGE: begin
            if (cnt_q == PRE_LAST) begin
               cnt_d   = '0;
               state_d = ST_WL_ON;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WL_ON: begin
            if (cnt_q == PULSE_LAST) begin
               cnt_d   = '0;
               state_d = ST_RECOVER;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RECOVER: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         wl_out[r] = (state_q == ST_WL_ON && row_sel_q[r]) ? VDD : VSS;
      end
   end

   assign pre_out = (state_q == ST_PRECHARGE) ? VDD : VSS;
   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_wordline_sequencer.sv
// Self-checking bench for wordline_sequencer (ROWS=12 so out-of-range codes exist).
module tb_wordline_sequencer;

   localparam int  ROWS  = 12;
   localparam int  PRE   = 2;
   localparam int  PULSE = 3;
   localparam int  AW    = 4;
   localparam real VDD   = 1.5;
   localparam real VSS   = 0.0;
   localparam real VTH   = 0.8;

   // observation vector layout: {lvl_ok, busy, done, err, pre, wl[ROWS-1:0]}
   localparam int B_PRE  = ROWS;
   localparam int B_ERR  = ROWS + 1;
   localparam int B_DONE = ROWS + 2;
   localparam int B_BUSY = ROWS + 3;
   localparam int W      = ROWS + 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic req = 1'b0;
   real  addr   [0:AW-1];
   real  wl_out [0:ROWS-1];
   real  pre_out;
   logic busy, done, err;

   int errors = 0;
   int checks = 0;

   // reference model: edge counter plus the schedule of the last accepted access
   int n       = 0;
   int cap_e   = -1000;
   int cap_a   = 0;
   int err_e   = -1000;
   int free_at = 0;

   wordline_sequencer #(
      .ROWS(ROWS), .PRE_CYC(PRE), .PULSE_CYC(PULSE),
      .VDD(VDD), .VSS(VSS), .VTH(VTH)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .addr(addr),
      .wl_out(wl_out), .pre_out(pre_out),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] observe();
      logic [ROWS-1:0] w;
      logic ok;
      ok = (pre_out == VDD || pre_out == VSS);
      for (int r = 0; r < ROWS; r++) begin
         w[r] = (wl_out[r] == VDD);
         if (wl_out[r] != VDD && wl_out[r] != VSS) ok = 1'b0;
      end
      return {ok, busy, done, err, pre_out == VDD, w};
   endfunction

   function automatic logic [W-1:0] expected();
      int d;
      logic [ROWS-1:0] w;
      d = n - cap_e;
      w = '0;
      if (d >= PRE && d < PRE + PULSE) w[cap_a] = 1'b1;
      return {1'b1, (d >= 0 && d <= PRE + PULSE), (d == PRE + PULSE + 1),
              (n == err_e), (d >= 0 && d < PRE), w};
   endfunction

   function automatic int thr_addr();
      int a;
      a = 0;
      for (int i = 0; i < AW; i++) if (addr[i] >= VTH) a += (1 << i);
      return a;
   endfunction

   task automatic model_reset();
      cap_e   = -1000;
      err_e   = -1000;
      free_at = 0;
   endtask

   task automatic set_addr(input int a);
      for (int i = 0; i < AW; i++)
         addr[i] = ((a >> i) & 1) ? $urandom_range(800, 1500) / 1000.0
                                  : $urandom_range(0, 799) / 1000.0;
   endtask

   // One clock: drive req at negedge, update the model at posedge, return 1 time unit later.
   task automatic tick(input logic rq);
      int a;
      @(negedge clk);
      req = rq;
      @(posedge clk);
      n++;
      if (rst) begin
         model_reset();
      end else if (req && n >= free_at) begin
         a = thr_addr();
         if (a >= ROWS) begin
            err_e   = n;
            free_at = n + 1;
         end else begin
            cap_e   = n;
            cap_a   = a;
            free_at = n + PRE + PULSE + 2;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      logic [W-1:0] o, e;
      set_addr(0);
      #1 rst = 1'b1;
      model_reset();
      #1;
      o = observe(); e = expected();
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_async: got %b want %b", o, e); end
      for (int k = 0; k < 2; k++) begin
         tick(1'b1);
         o = observe(); e = expected();
         checks++;
         if (o !== e) begin errors++; $display("FAIL reset_hold cyc%0d: got %b want %b", k, o, e); end
      end
      rst = 1'b0;
   endtask

   task automatic test_addr0();
      logic [W-1:0] o, e;
      logic [9:0] pre_m, wl0_m, want_pre, want_wl0;
      int done_cyc;
      pre_m = '0; wl0_m = '0; done_cyc = -1;
      want_pre = 10'b0000000110;
      want_wl0 = 10'b0000111000;
      for (int i = 0; i < AW; i++) addr[i] = 0.0;
      for (int k = 1; k <= 9; k++) begin
         tick(k == 1);
         o = observe(); e = expected();
         checks++;
         if (o !== e) begin errors++; $display("FAIL addr0 cyc%0d: got %b want %b", k, o, e); end
         pre_m[k] = o[B_PRE];
         wl0_m[k] = o[0];
         if (o[B_DONE] && done_cyc < 0) done_cyc = k;
      end
      checks++;
      if (pre_m !== want_pre) begin errors++; $display("FAIL addr0_pre_cycles: got %b want %b", pre_m, want_pre); end
      checks++;
      if (wl0_m !== want_wl0) begin errors++; $display("FAIL addr0_wl_cycles: got %b want %b", wl0_m, want_wl0); end
      checks++;
      if (done_cyc != 7) begin errors++; $display("FAIL addr0_done_cycle: got %0d want 7", done_cyc); end
   endtask

   task automatic test_threshold();
      logic [W-1:0] o, e;
      logic [ROWS-1:0] want;
      want = '0;
      want[10] = 1'b1;
      addr[0] = 0.79; addr[1] = 0.8; addr[2] = 0.0; addr[3] = 1.5;
      for (int k = 1; k <= 8; k++) begin
         tick(k == 1);
         o = observe(); e = expected();
         checks++;
         if (o !== e) begin errors++; $display("FAIL threshold cyc%0d: got %b want %b", k, o, e); end
         if (k == 3) begin
            checks++;
            if (o[ROWS-1:0] !== want) begin errors++; $display("FAIL threshold_row: got %b want %b", o[ROWS-1:0], want); end
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [W-1:0] o, e, want;
      int codes [4];
      codes = '{13, 12, 15, 14};
      want = '0;
      want[W-1]  = 1'b1;
      want[B_ERR] = 1'b1;
      foreach (codes[j]) begin
         set_addr(codes[j]);
         tick(1'b1);
         o = observe(); e = expected();
         checks++;
         if (o !== e) begin errors++; $display("FAIL oor_model a=%0d: got %b want %b", codes[j], o, e); end
         checks++;
         if (o !== want) begin errors++; $display("FAIL oor_pulse a=%0d: got %b want %b", codes[j], o, want); end
         tick(1'b0);
         o = observe(); e = expected();
         checks++;
         if (o !== e) begin errors++; $display("FAIL oor_after a=%0d: got %b want %b", codes[j], o, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] o, e;
      int done_cyc, pre2, saw7;
      done_cyc = -1; pre2 = -1; saw7 = 0;
      set_addr(3);
      for (int k = 1; k <= 16; k++) begin
         tick(k <= 8);
         if (k == 1) set_addr(7);
         o = observe(); e = expected();
         checks++;
         if (o !== e) begin errors++; $display("FAIL b2b cyc%0d: got %b want %b", k, o, e); end
         checks++;
         if ((o[3] && o[7]) || (o[B_PRE] && |o[ROWS-1:0])) begin
            errors++; $display("FAIL b2b_overlap cyc%0d: got %b", k, o);
         end
         if (o[B_DONE] && done_cyc < 0) done_cyc = k;
         if (done_cyc > 0 && k > done_cyc && o[B_PRE] && pre2 < 0) pre2 = k;
         if (o[7]) saw7++;
      end
      checks++;
      if (done_cyc != 7 || pre2 != 8) begin
         errors++; $display("FAIL b2b_restart: got done=%0d pre=%0d want done=7 pre=8", done_cyc, pre2);
      end
      checks++;
      if (saw7 != PULSE) begin errors++; $display("FAIL b2b_row7_cycles: got %0d want %0d", saw7, PULSE); end
   endtask

   task automatic test_ignored();
      logic [W-1:0] o, e;
      int dones;
      dones = 0;
      set_addr(2);
      for (int k = 1; k <= 12; k++) begin
         if (k == 4) set_addr(9);
         tick(k == 1 || k == 4);
         o = observe(); e = expected();
         checks++;
         if (o !== e) begin errors++; $display("FAIL ignored cyc%0d: got %b want %b", k, o, e); end
         if (o[B_DONE]) dones++;
      end
      checks++;
      if (dones != 1) begin errors++; $display("FAIL ignored_done_count: got %0d want 1", dones); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] o, e;
      int dones;
      dones = 0;
      set_addr(5);
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      o = observe(); e = expected();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rstmid_pre: got %b want %b", o, e); end
      #2 rst = 1'b1;
      model_reset();
      #1;
      o = observe(); e = expected();
      checks++;
      if (o !== e || wl_out[5] != 0.0) begin
         errors++; $display("FAIL rstmid_async: got %b wl5=%f want %b wl5=0.0", o, wl_out[5], e);
      end
      tick(1'b0);
      tick(1'b0);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick(1'b0);
         o = observe(); e = expected();
         checks++;
         if (o !== e) begin errors++; $display("FAIL rstmid_after cyc%0d: got %b want %b", k, o, e); end
         if (o[B_DONE]) dones++;
      end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
   endtask

   task automatic test_random();
      logic [W-1:0] o, e;
      for (int k = 0; k < 400; k++) begin
         set_addr($urandom_range(0, 15));
         tick($urandom_range(0, 2) == 0);
         o = observe(); e = expected();
         checks++;
         if (o !== e) begin errors++; $display("FAIL random cyc%0d: got %b want %b", k, o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_addr0();
      test_threshold();
      test_out_of_range();
      test_back_to_back();
      test_ignored();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wordline_sequencer.md
WORDLINE_SEQUENCER -- requirements
Module: wordline_sequencer

Interface
REQ-001 The block SHALL have parameter ROWS, default 16, meaning number of wordlines (2 or more, need not be a power of two).
REQ-002 The block SHALL have parameter PRE_CYC, default 2, meaning bitline precharge duration in clk cycles (1 or more).
REQ-003 The block SHALL have parameter PULSE_CYC, default 3, meaning wordline-high duration in clk cycles (1 or more).
REQ-004 The block SHALL have parameter VDD, default 1.5, meaning real high output level in volts.
REQ-005 The block SHALL have parameter VSS, default 0.0, meaning real low output level in volts.
REQ-006 The block SHALL have parameter VTH, default 0.8, meaning real-to-logic input threshold in volts.
REQ-007 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-008 The block SHALL have port clk, input, 1 bit, system clock, rising-edge active.
REQ-009 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-010 The block SHALL have port req, input, 1 bit, access request (logic).
REQ-011 The block SHALL have port addr, input, real [0:AW-1] with AW=$clog2(ROWS), row address levels; index 0 = LSB.
REQ-012 The block SHALL have port wl_out, output, real [0:ROWS-1], wordline levels.
REQ-013 The block SHALL have port pre_out, output, real, bitline precharge enable level.
REQ-014 The block SHALL have port busy, output, 1 bit, high outside IDLE.
REQ-015 The block SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-016 The block SHALL have port err, output, 1 bit, one-cycle out-of-range-address pulse.

Function
REQ-017 Each addr bit SHALL be thresholded as logic 1 if level >= VTH, else logic 0.
REQ-018 The thresholded addr SHALL be captured into an internal register only on a rising clk edge where req=1 and the state is IDLE; a req in any other state SHALL be ignored.
REQ-019 The FSM SHALL have states IDLE, PRECHARGE, WL_ON and RECOVER.
REQ-020 On a capture with captured address >= ROWS, the FSM SHALL stay in IDLE and pulse err for the next cycle, with no precharge and no wordline activity.
REQ-021 On a capture with a valid address, the FSM SHALL move IDLE->PRECHARGE and hold PRECHARGE for exactly PRE_CYC cycles, with pre_out=VDD.
REQ-022 After PRECHARGE, the FSM SHALL hold WL_ON for exactly PULSE_CYC cycles.
REQ-023 In WL_ON, wl_out[a]=VDD for captured address a and all other wordlines =VSS; address 0 SHALL select row 0 (true binary one-hot decode, 1<<a).
REQ-024 After WL_ON, the FSM SHALL spend 1 cycle in RECOVER with all outputs at VSS, then return to IDLE with done=1 for exactly that first IDLE cycle.
REQ-025 pre_out and any wl_out SHALL never be at VDD in the same cycle (break-before-make).
REQ-026 In IDLE, all wl_out and pre_out SHALL be VSS.
REQ-027 Request-to-wordline latency SHALL be PRE_CYC+1 clock edges; req-to-done latency SHALL be PRE_CYC+PULSE_CYC+2 edges.
REQ-028 A req sampled in the cycle done is high SHALL be accepted, giving back-to-back accesses.
REQ-029 Addr changes after capture SHALL NOT affect wl_out.
REQ-030 All outputs SHALL be driven from registered state, with no combinational path from addr to wl_out.

Reset
REQ-031 While rst=1, and immediately on its assertion with no clock required, state SHALL be IDLE, all wl_out=VSS, pre_out=VSS, busy=0, done=0, err=0, and the address register and cycle counter SHALL be 0.
REQ-032 A reset asserted mid-access (any state) SHALL abort that access with no done pulse.

Structure
REQ-033 VDD/VSS/VTH typical values and an FSM state enum SHALL live in shared package sram_pkg.
REQ-034 The block SHALL contain one sub-module, onehot_decoder (parametrised ROWS; logic address in, logic one-hot out plus out-of-range flag), instantiated once.
REQ-035 Real/logic conversion SHALL occur only at the wordline_sequencer ports.

Verification
REQ-036 Reset test: rst=1 mid-WL_ON with address 5 -> wl_out[5] drops to 0.0 with no clock edge, busy=0, and no done pulse.
REQ-037 Address 0 test: addr levels {0.0,0.0,0.0,0.0}, req pulse, defaults -> pre_out=1.5 for cycles 1-2, wl_out[0]=1.5 for cycles 3-5, done at cycle 7.
REQ-038 Threshold test: addr={0.79,0.8,0.0,1.5} -> captured address 10, so only wl_out[10]=1.5 in WL_ON.
REQ-039 Out-of-range test: ROWS=12, addr=13 -> err pulse one cycle, busy stays 0, all wl_out remain 0.0.
REQ-040 Back-to-back test: addresses 3 then 7, with the second req held during busy and asserted in the done cycle -> second access starts immediately, wl_out[3] and wl_out[7] are never high together, and pre_out never overlaps any wordline.
REQ-041 Ignored-request test: req with addr=9 issued during WL_ON of address 2 -> no effect, and a single done pulse.
